flag_buf_fifo: RTL
==================

# flag_buf_fifo

Parametrised successor to the single-word flag buffer: a 2^B-entry first-word-fall-through mailbox. It is written by `set_flag`/`din`, read by `clr_flag`, and keeps the `flag` (data available) semantics of the one-word buffer. It adds an occupancy count, a full indication, sticky overflow/underflow error flags, and a selectable full-policy (drop newest or overwrite oldest). It sits between a bursty producer, such as a UART receiver, and a slower consumer, so that back-to-back words are not lost.

## Interface
- `W`, default 8: data word width in bits.
- `B`, default 2: address bits. Depth is 2^B entries, and B must be at least 1.
- `OVERWRITE`, default 0: full-policy. 0 = drop the incoming word. 1 = discard the oldest word and accept the new one.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `set_flag`  in  1  push request; `din` is written when accepted.
- `clr_flag`  in  1  pop request; consumes the word on `dout`.
- `din`  in  W  write data.
- `clr_err`  in  1  clears `ovf` and `udf`.
- `flag`  out  1  1 when at least one word is stored (count > 0).
- `full`  out  1  1 when count = 2^B.
- `dout`  out  W  oldest stored word (head). Forced to 0 when `flag` = 0.
- `count`  out  B+1  number of stored words, range 0..2^B.
- `ovf`  out  1  sticky: a push occurred while full.
- `udf`  out  1  sticky: a pop occurred while empty.

## Operation
- Storage is a circular array of 2^B × W with write pointer `wr_ptr` and read pointer `rd_ptr`, each B bits wide.
  - Pointers wrap naturally from 2^B−1 to 0.
  - `count` is held in a register, not derived from the pointers, so that full and empty are unambiguous.
- Per-cycle actions, decided on the state before the edge:
  - Push only, not full: write `din` at `wr_ptr`; `wr_ptr`+1; `count`+1.
  - Push only, full, OVERWRITE=0: `din` is discarded; pointers and count are unchanged; set `ovf`.
  - Push only, full, OVERWRITE=1: write `din` at `wr_ptr`; `wr_ptr`+1 and `rd_ptr`+1; count stays 2^B; set `ovf`.
  - Pop only, not empty: `rd_ptr`+1; `count`−1.
  - Pop only, empty: no state change; set `udf`.
  - Push and pop together, not empty (this includes full): write and read both occur; both pointers advance; count is unchanged; no error is flagged.
  - Push and pop together, empty: the push is accepted and count becomes 1. The pop is ignored and `udf` is set. The word pushed is not consumed.
- Error clearing:
  - `clr_err` clears `ovf` and `udf` at the next edge.
  - If an error event occurs in the same cycle as `clr_err`, the set wins and the flag reads 1.
- Output derivation:
  - `flag` = (count ≠ 0).
  - `full` = (count = 2^B).
  - `dout` = storage[`rd_ptr`] when `flag`, otherwise 0.
- Reset values:
  - Pointers and `count` are 0.
  - `flag`, `full`, `ovf`, `udf` are 0.
  - `dout` is 0.
  - Storage contents are not cleared.
- A reset in mid-operation discards every stored word. Any `set_flag`/`clr_flag` in the reset cycle is ignored.

## Timing
- All state updates on the rising edge of `clk`. Outputs are functions of registered state only; there is no combinational path from inputs to outputs.
- Push to visibility takes 1 cycle. After the edge that accepts a push into an empty buffer, `flag`=1, `dout`=`din`, and `count`=1.
- Pop takes effect at the edge. After it, `dout` shows the next word, or 0 with `flag`=0 if the buffer is now empty.
- Full throughput: one push and one pop every cycle indefinitely, with no bubbles.
- `ovf` and `udf` assert 1 cycle after the offending request and hold until `clr_err` or `reset`.

## Test plan
All scenarios use W=8, B=2.
1. **Reset then fill/drain:** reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles. Required: `count` steps 1→4, `full`=1 after the 4th push, `dout`=0x11 throughout. Then pop 4 times. Required: `dout` goes 0x22, 0x33, 0x44, then 0 with `flag`=0. `ovf` and `udf` stay 0.
2. **Overflow, OVERWRITE=0:** fill with 0x01..0x04, then push 0x55. Required: `ovf`=1, `count`=4, and draining yields 0x01..0x04. Then pulse `clr_err`. Required: `ovf`=0.
3. **Overflow, OVERWRITE=1:** fill with 0x01..0x04, then push 0x55. Required: `ovf`=1, `count`=4, and draining yields 0x02, 0x03, 0x04, 0x55.
4. **Simultaneous push/pop:**
   - Full buffer, push 0xAA with pop. Required: `count` stays 4, `dout` advances, 0xAA is the last word drained, no `ovf`.
   - Empty buffer, push 0x77 with pop. Required: `count`=1, `dout`=0x77, `udf`=1.
5. **Wrap-around:** run 10 cycles of push+pop with incrementing data after a single pre-push. Required: output order is preserved across pointer wrap and `count` stays 1. Then pop on an empty buffer together with `clr_err`. Required: `udf`=1, because set wins.
6. **Reset mid-operation:** with 3 words stored, assert `reset` together with `set_flag`. Required: the next cycle shows `count`=0, `flag`=0, `dout`=0, `ovf`=`udf`=0, and a subsequent push of 0x99 appears on `dout`.

Source files
------------

// File: rtl/flag_buf_fifo.sv
// Purpose: 2^B-entry first-word-fall-through mailbox with flag/full/count and sticky ovf/udf errors.
// Latency: a push is visible on flag/dout/count one cycle after the accepting edge; a pop takes effect at the edge.
// Backpressure: none on the input side; a push into a full buffer is dropped (OVERWRITE=0) or evicts the oldest word (OVERWRITE=1), and sets ovf.
module flag_buf_fifo #(
    parameter int W         = 8,
    parameter int B         = 2,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set_flag,
    input  logic         clr_flag,
    input  logic [W-1:0] din,
    input  logic         clr_err,
    output logic         flag,
    output logic         full,
    output logic [W-1:0] dout,
    output logic [B:0]   count,
    output logic         ovf,
    output logic         udf
);

    localparam int unsigned DEPTH    = 1 << B;
    localparam logic [B:0]  CNT_FULL = (B+1)'(DEPTH);
    localparam logic [B:0]  CNT_ONE  = (B+1)'(1);
    localparam logic [B-1:0] PTR_ONE = B'(1);

    // Storage and state registers. Storage is deliberately left unreset:
    // count alone decides which entries are meaningful.
    logic [W-1:0] r_mem [DEPTH];
    logic [B-1:0] r_wr_ptr;
    logic [B-1:0] r_rd_ptr;
    logic [B:0]   r_count;
    logic         r_ovf;
    logic         r_udf;

    // Decoded per-cycle actions, all derived from the state before the edge.
    logic         w_empty;
    logic         w_full;
    logic         w_wr_en;
    logic         w_rd_adv;
    logic         w_ovf_set;
    logic         w_udf_set;
    logic [B:0]   w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    // Decode the push/pop request pair into storage, pointer and error actions.
    always_comb begin
        w_wr_en   = 1'b0;
        w_rd_adv  = 1'b0;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        unique case ({set_flag, clr_flag})
            2'b10: begin
                // Push only: accept unless full; when full either drop the
                // word or evict the head to make room for it.
                if (!w_full) begin
                    w_wr_en = 1'b1;
                end else begin
                    w_ovf_set = 1'b1;
                    if (OVERWRITE) begin
                        w_wr_en  = 1'b1;
                        w_rd_adv = 1'b1;
                    end
                end
            end
            2'b01: begin
                // Pop only: consume the head, or flag an underflow if empty.
                if (!w_empty) begin
                    w_rd_adv = 1'b1;
                end else begin
                    w_udf_set = 1'b1;
                end
            end
            2'b11: begin
                // Push and pop: the write always lands (a full buffer frees a
                // slot in the same cycle); the pop only counts when a word
                // already existed, so a word pushed into an empty buffer is
                // never consumed in its own cycle.
                w_wr_en = 1'b1;
                if (!w_empty) begin
                    w_rd_adv = 1'b1;
                end else begin
                    w_udf_set = 1'b1;
                end
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    // Next occupancy: +1 on a write without a head advance, -1 on a head
    // advance without a write, otherwise unchanged (includes full overwrite).
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_en, w_rd_adv})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; requests in the reset cycle are ignored.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Sticky error flags: a new error event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
            r_udf <= w_udf_set | (r_udf & ~clr_err);
        end
    end

    // Outputs come from registered state only; dout is masked when empty.
    assign flag  = ~w_empty;
    assign full  = w_full;
    assign count = r_count;
    assign dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule
